// File: rtl/div_pkg.sv
// Shared widths, state codes, handshake constants and opcodes for the
// multi-cycle MIPS32 divider.
package div_pkg;

    localparam int REG_BUS_W        = 32;
    localparam int DOUBLE_REG_BUS_W = 64;
    localparam int DIV_ITERATIONS   = 32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Two's-complement negate when cond is set, pass through otherwise.
    function automatic logic [REG_BUS_W-1:0] neg_if(input logic [REG_BUS_W-1:0] value,
                                                    input logic                  cond);
        logic [REG_BUS_W-1:0] res;
        if (cond) begin
            res = ~value + 32'd1;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_if.sv
// Execute-stage to divider handshake: operands and start/annul in,
// 64-bit {remainder, quotient} and ready back.
interface div_if;
    import div_pkg::*;

    logic                        signed_div_i;
    logic [REG_BUS_W-1:0]        opdata1_i;
    logic [REG_BUS_W-1:0]        opdata2_i;
    logic                        start_i;
    logic                        annul_i;
    logic [DOUBLE_REG_BUS_W-1:0] result_o;
    logic                        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per clock. Operands are
// reduced to magnitudes on capture and the signs are restored on the way out.
module div
    import div_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    div_state_e                  state_r,     state_s;
    logic [5:0]                  cnt_r,       cnt_s;
    logic [64:0]                 work_r,      work_s;
    logic [REG_BUS_W-1:0]        divisor_r,   divisor_s;
    logic                        neg_quot_r,  neg_quot_s;
    logic                        neg_rem_r,   neg_rem_s;
    logic [DOUBLE_REG_BUS_W-1:0] result_r,    result_s;
    logic                        ready_r,     ready_s;

    logic [64:0]                 shifted_s;
    logic [32:0]                 trial_s;
    logic [REG_BUS_W-1:0]        dividend_abs_s;
    logic [REG_BUS_W-1:0]        divisor_abs_s;

    // Magnitudes of the incoming operands; only meaningful for the capture edge.
    always_comb begin
        dividend_abs_s = neg_if(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[31]);
        divisor_abs_s  = neg_if(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[31]);
    end

    // One restoring step: shift, then try to take the divisor off the top 33 bits.
    always_comb begin
        shifted_s = work_r << 6'd1;
        trial_s   = shifted_s[64:32] - {1'b0, divisor_r};
    end

    // Next-state and datapath updates; every register has a value in every state.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        work_s     = work_r;
        divisor_s  = divisor_r;
        neg_quot_s = neg_quot_r;
        neg_rem_s  = neg_rem_r;
        result_s   = result_r;
        ready_s    = ready_r;

        case (state_r)
            DIV_FREE: begin
                ready_s  = DIV_RESULT_NOT_READY;
                result_s = 64'd0;
                cnt_s    = 6'd0;
                if ((bus.start_i == DIV_START) && !bus.annul_i) begin
                    neg_quot_s = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                    neg_rem_s  = bus.signed_div_i & bus.opdata1_i[31];
                    work_s     = {33'd0, dividend_abs_s};
                    divisor_s  = divisor_abs_s;
                    if (bus.opdata2_i == 32'd0) begin
                        state_s = DIV_BY_ZERO;
                    end else begin
                        state_s = DIV_ON;
                    end
                end else begin
                    state_s = DIV_FREE;
                end
            end

            DIV_BY_ZERO: begin
                work_s   = 65'd0;
                result_s = 64'd0;
                ready_s  = DIV_RESULT_READY;
                state_s  = DIV_END;
            end

            DIV_ON: begin
                if (bus.annul_i) begin
                    state_s  = DIV_FREE;
                    cnt_s    = 6'd0;
                    ready_s  = DIV_RESULT_NOT_READY;
                    result_s = 64'd0;
                end else if (cnt_r == 6'(DIV_ITERATIONS)) begin
                    // All quotient bits are in; restore signs as the result is latched.
                    state_s  = DIV_END;
                    cnt_s    = 6'd0;
                    ready_s  = DIV_RESULT_READY;
                    result_s = {neg_if(work_r[63:32], neg_rem_r),
                                neg_if(work_r[31:0],  neg_quot_r)};
                end else begin
                    if (trial_s[32] == 1'b0) begin
                        work_s = {trial_s, shifted_s[31:1], 1'b1};
                    end else begin
                        work_s = {shifted_s[64:1], 1'b0};
                    end
                    cnt_s = cnt_r + 6'd1;
                end
            end

            DIV_END: begin
                if (bus.start_i == DIV_START) begin
                    ready_s = DIV_RESULT_READY;
                    state_s = DIV_END;
                end else begin
                    ready_s  = DIV_RESULT_NOT_READY;
                    result_s = 64'd0;
                    state_s  = DIV_FREE;
                end
            end

            default: begin
                state_s  = DIV_FREE;
                cnt_s    = 6'd0;
                ready_s  = DIV_RESULT_NOT_READY;
                result_s = 64'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DIV_FREE;
            cnt_r      <= 6'd0;
            work_r     <= 65'd0;
            divisor_r  <= 32'd0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            result_r   <= 64'd0;
            ready_r    <= DIV_RESULT_NOT_READY;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            work_r     <= work_s;
            divisor_r  <= divisor_s;
            neg_quot_r <= neg_quot_s;
            neg_rem_r  <= neg_rem_s;
            result_r   <= result_s;
            ready_r    <= ready_s;
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: an arithmetic reference plus a protocol
// model checked every cycle, and literal results for each directed vector.
module tb_div;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_if dif();

    div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Protocol model: idle -> busy for a fixed number of edges -> done while start held.
    int          mode;
    int          left;
    bit          zero_op;
    bit          exp_ready;
    logic [63:0] exp_val;
    bit          armed;

    always @(posedge clk) begin
        if (rst) begin
            mode      <= 0;
            exp_ready <= 1'b0;
            armed     <= 1'b1;
        end else begin
            case (mode)
                0: if (dif.start_i && !dif.annul_i) begin
                    exp_val <= ref_div(dif.signed_div_i, dif.opdata1_i, dif.opdata2_i);
                    zero_op <= (dif.opdata2_i == 32'd0);
                    left    <= (dif.opdata2_i == 32'd0) ? 1 : 33;
                    mode    <= 1;
                end
                1: if (dif.annul_i && !zero_op) begin
                    mode <= 0;
                end else if (left == 1) begin
                    mode      <= 2;
                    exp_ready <= 1'b1;
                end else begin
                    left <= left - 1;
                end
                2: if (!dif.start_i) begin
                    mode      <= 0;
                    exp_ready <= 1'b0;
                end
                default: mode <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            checks = checks + 1;
            if (dif.ready_o !== exp_ready) begin
                errors = errors + 1;
                $display("FAIL model_ready t=%0t got=%b want=%b", $time, dif.ready_o, exp_ready);
            end
            checks = checks + 1;
            if (dif.result_o !== (exp_ready ? exp_val : 64'd0)) begin
                errors = errors + 1;
                $display("FAIL model_result t=%0t got=%h want=%h", $time, dif.result_o,
                         exp_ready ? exp_val : 64'd0);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Issue one divide, measure latency, check the literal result, hold, then release.
    task automatic run_op(input string name, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] want,
                          input int want_lat, input int hold);
        int n;
        @(negedge clk);
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        dif.annul_i      = 1'b0;
        @(posedge clk);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n = n + 1;
            #1;
            dif.opdata1_i = $urandom;
            dif.opdata2_i = $urandom;
            if (dif.ready_o) break;
        end
        check({name, "_latency"}, 64'(n), 64'(want_lat));
        check({name, "_result"}, dif.result_o, want);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_ready"}, 64'(dif.ready_o), 64'd1);
            check({name, "_hold_result"}, dif.result_o, want);
        end
        @(negedge clk);
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_drop_ready"}, 64'(dif.ready_o), 64'd0);
        check({name, "_drop_result"}, dif.result_o, 64'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        armed  = 1'b0;
        rst    = 1'b1;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd0;
        dif.opdata2_i    = 32'd0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(dif.ready_o), 64'd0);
        check("reset_result", dif.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_7_2",   1'b0, 32'd7, 32'd2, {32'h0000_0001, 32'h0000_0003}, 33, 0);
        run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        run_op("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
        run_op("divu_by0",   1'b0, 32'h1234_5678, 32'd0, 64'd0, 1, 0);
        run_op("div_by0",    1'b1, 32'h8000_0000, 32'd0, 64'd0, 1, 1);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 0);
        run_op("divu_big",   1'b0, 32'hFFFF_FFFF, 32'h0001_0000, {32'h0000_FFFF, 32'h0000_FFFF}, 33, 0);

        // Annul part-way through: no result, then a fresh divide is accepted.
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd1000;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        @(negedge clk);
        dif.annul_i = 1'b0;
        repeat (40) @(negedge clk);
        check("annul_no_ready", 64'(dif.ready_o), 64'd0);
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

        // Reset mid-operation clears outputs on that edge.
        @(negedge clk);
        dif.signed_div_i = 1'b1;
        dif.opdata1_i    = 32'd12345;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", 64'(dif.ready_o), 64'd0);
        check("midrst_result", dif.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0);

        // Held start past ready, operands scrambled during the divide.
        run_op("div_hold", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 5);

        // Simultaneous start and annul in idle must not launch anything.
        @(negedge clk);
        dif.opdata1_i = 32'd9;
        dif.opdata2_i = 32'd3;
        dif.start_i   = 1'b1;
        dif.annul_i   = 1'b1;
        repeat (3) @(negedge clk);
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;
        repeat (40) @(negedge clk);
        check("start_annul_idle", 64'(dif.ready_o), 64'd0);

        run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33, 2);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
